// File: rtl/stream_pkg.sv
// stream_pkg: shared types and constants for the stream packet FIFO.
//   state_e    : overflow handling state (ST_ACCEPT, ST_DROP)
//   DROP_CNT_W : width of the dropped-packet counter
//   sat_inc    : saturating increment for the drop counter
package stream_pkg;

    typedef enum logic [0:0] {
        ST_ACCEPT = 1'b0,
        ST_DROP   = 1'b1
    } state_e;

    localparam int DROP_CNT_W = 16;

    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] val);
        return (val == '1) ? val : val + DROP_CNT_W'(1);
    endfunction

endpackage

// File: rtl/stream_sdp_ram.sv
// stream_sdp_ram: simple dual-port storage, synchronous write, asynchronous read.
// Ports:
//   clk     - clock
//   we_i    - write enable
//   waddr_i - write address
//   wdata_i - write data
//   raddr_i - read address
//   rdata_o - read data (combinational from storage)
// Contents are intentionally not reset.
module stream_sdp_ram #(
    parameter  int WIDTH = 10,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stream_pkt_fifo.sv
// stream_pkt_fifo: store-and-forward packet FIFO for one crossbar master port.
// A packet becomes visible at the output only after its last word is written.
// Ports:
//   clk, rst_n                                - clock, async active-low reset
//   s_data_i/s_id_i/s_last_i/s_valid_i/s_ready_o - input stream
//   m_data_o/m_id_o/m_last_o/m_valid_o/m_ready_i - output stream
//   pkt_count_o                               - complete packets held
//   drop_count_o                              - dropped packets (saturating)
// Build option: define STREAM_PKT_FIFO_DROP_EN to drop packets that overflow
// the buffer; otherwise an oversized packet stalls the input permanently.
//
// state     | meaning
// ST_ACCEPT | words are written into the buffer
// ST_DROP   | remainder of an overflowing packet is discarded
module stream_pkt_fifo
    import stream_pkg::*;
#(
    parameter  int T_DATA_WIDTH = 8,
    parameter  int S_DATA_COUNT = 2,
    parameter  int DEPTH        = 16,
    localparam int T_ID___WIDTH = $clog2(S_DATA_COUNT),
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [T_DATA_WIDTH-1:0] s_data_i,
    input  logic [T_ID___WIDTH-1:0] s_id_i,
    input  logic                    s_last_i,
    input  logic                    s_valid_i,
    output logic                    s_ready_o,
    output logic [T_DATA_WIDTH-1:0] m_data_o,
    output logic [T_ID___WIDTH-1:0] m_id_o,
    output logic                    m_last_o,
    output logic                    m_valid_o,
    input  logic                    m_ready_i,
    output logic [CNT_W-1:0]        pkt_count_o,
    output logic [DROP_CNT_W-1:0]   drop_count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int EW = T_DATA_WIDTH + T_ID___WIDTH + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    commit_ptr_q, commit_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] pkt_cnt_q, pkt_cnt_d;
    logic             rdy_en_q, rdy_en_d;
    logic [PW-1:0]    used;
    logic             full;
    logic             partial;
    logic             wr_en;
    logic             commit;
    logic             rd_last;
    logic [EW-1:0]    rd_entry;

    assign used      = wr_ptr_q - rd_ptr_q;
    assign full      = (used == PW'(DEPTH));
    assign partial   = (wr_ptr_q != commit_ptr_q);
    assign m_valid_o = (commit_ptr_q != rd_ptr_q);

    assign {m_data_o, m_id_o, m_last_o} = rd_entry;
    assign pkt_count_o = pkt_cnt_q;

`ifdef STREAM_PKT_FIFO_DROP_EN
    state_e                state_q, state_d;
    logic [DROP_CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    assign drop_count_o = drop_cnt_q;
`else
    assign drop_count_o = '0;
`endif

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pkt_cnt_d    = pkt_cnt_q;
        rdy_en_d     = 1'b1;
        wr_en        = 1'b0;
`ifdef STREAM_PKT_FIFO_DROP_EN
        state_d    = state_q;
        drop_cnt_d = drop_cnt_q;
        // Ready stays high when full with a partial packet so that packet can
        // be detected as oversized and dropped instead of deadlocking.
        if (state_q == ST_DROP) begin
            s_ready_o = rdy_en_q;
        end else begin
            s_ready_o = rdy_en_q & (~full | partial);
        end
        if (s_valid_i && s_ready_o) begin
            if (state_q == ST_DROP) begin
                if (s_last_i) begin
                    state_d = ST_ACCEPT;
                end
            end else if (full) begin
                wr_ptr_d   = commit_ptr_q;
                drop_cnt_d = sat_inc(drop_cnt_q);
                if (!s_last_i) begin
                    state_d = ST_DROP;
                end
            end else begin
                wr_en = 1'b1;
            end
        end
`else
        s_ready_o = rdy_en_q & ~full;
        wr_en     = s_valid_i & s_ready_o;
`endif
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            if (s_last_i) begin
                commit_ptr_d = wr_ptr_q + PW'(1);
            end
        end
        if (m_valid_o && m_ready_i) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        commit  = wr_en & s_last_i;
        rd_last = m_valid_o & m_ready_i & m_last_o;
        case ({commit, rd_last})
            2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
            2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
            default: pkt_cnt_d = pkt_cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            pkt_cnt_q    <= '0;
            rdy_en_q     <= 1'b0;
`ifdef STREAM_PKT_FIFO_DROP_EN
            state_q      <= ST_ACCEPT;
            drop_cnt_q   <= '0;
`endif
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            pkt_cnt_q    <= pkt_cnt_d;
            rdy_en_q     <= rdy_en_d;
`ifdef STREAM_PKT_FIFO_DROP_EN
            state_q      <= state_d;
            drop_cnt_q   <= drop_cnt_d;
`endif
        end
    end

    stream_sdp_ram #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk     (clk),
        .we_i    (wr_en),
        .waddr_i (wr_ptr_q[AW-1:0]),
        .wdata_i ({s_data_i, s_id_i, s_last_i}),
        .raddr_i (rd_ptr_q[AW-1:0]),
        .rdata_o (rd_entry)
    );

endmodule

// File: doc/stream_pkt_fifo.md
STREAM_PKT_FIFO -- requirements
Module: stream_pkt_fifo

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 The block SHALL have these parameters, one per line:
- T_DATA_WIDTH, 8, payload width.
- S_DATA_COUNT, 2, number of crossbar sources; sets the id width.
- DEPTH, 16, buffer words; power of two, at least 2.
- T_ID___WIDTH, $clog2(S_DATA_COUNT), localparam.
REQ-003 The block SHALL have these ports, one per line (name, direction, width, meaning):
- clk, in, 1, clock.
- rst_n, in, 1, async active-low reset.
- s_data_i, in, T_DATA_WIDTH, input word from one crossbar master port.
- s_id_i, in, T_ID___WIDTH, source id of the input word.
- s_last_i, in, 1, last word of the packet.
- s_valid_i, in, 1, input valid.
- s_ready_o, out, 1, input ready.
- m_data_o, out, T_DATA_WIDTH, output word.
- m_id_o, out, T_ID___WIDTH, output source id.
- m_last_o, out, 1, output last.
- m_valid_o, out, 1, output valid.
- m_ready_i, in, 1, output ready.
- pkt_count_o, out, $clog2(DEPTH+1), number of complete packets held.
- drop_count_o, out, 16, number of dropped packets; saturates at 0xFFFF.

Function
REQ-004 The block SHALL be a store-and-forward receiver: no word of a packet is presented at the output until the last word of that packet has been written.
REQ-005 Each stored entry SHALL hold {data, id, last}.
REQ-006 The block SHALL keep three pointers, each DEPTH-indexed with one wrap bit: wr_ptr, commit_ptr and rd_ptr.
REQ-007 The buffer SHALL be full when wr_ptr-rd_ptr equals DEPTH.
REQ-008 The buffer SHALL contain committed data when commit_ptr differs from rd_ptr.
REQ-009 An input transfer SHALL occur on a clock edge where s_valid_i and s_ready_o are both high.
REQ-010 An output transfer SHALL occur on a clock edge where m_valid_o and m_ready_i are both high.
REQ-011 An accepted non-dropped word SHALL be written at wr_ptr, and wr_ptr SHALL increment by one.
REQ-012 If the accepted word has last set, commit_ptr SHALL be loaded with the incremented wr_ptr on the same edge.
REQ-013 m_valid_o SHALL equal (commit_ptr != rd_ptr).
REQ-014 m_data_o, m_id_o and m_last_o SHALL show the entry at rd_ptr, with zero-cycle read (combinational from storage).
REQ-015 A packet committed on edge N SHALL make m_valid_o high after edge N, with one cycle of latency.
REQ-016 An output transfer SHALL increment rd_ptr.
REQ-017 pkt_count_o SHALL increment on commit and decrement on an output transfer with m_last_o set.
REQ-018 If a commit and a last-word output transfer occur on the same edge, pkt_count_o SHALL be unchanged.
REQ-019 A write and a read on the same edge SHALL both take effect; a full buffer SHALL accept a word on the edge where a read frees space only on the following cycle, so s_ready_o has no combinational path from m_ready_i.
REQ-020 Pointer wrap SHALL be by natural modulo 2*DEPTH arithmetic.
REQ-021 m_valid_o SHALL never depend combinationally on s_valid_i.
REQ-022 Once m_valid_o is high, the block SHALL hold m_valid_o high and the output data stable until the output transfer occurs.

Reset
REQ-023 While rst_n is low, all pointers, pkt_count_o, drop_count_o and the state register SHALL be 0, state SHALL be ACCEPT, s_ready_o SHALL be 0 and m_valid_o SHALL be 0.
REQ-024 s_ready_o SHALL rise on the first clock edge after reset release.
REQ-025 Storage contents SHALL not be reset.
REQ-026 A reset asserted mid-packet SHALL discard all buffered and partial packets.

Configuration
REQ-027 The macro STREAM_PKT_FIFO_DROP_EN SHALL select the overflow behaviour.
REQ-028 With STREAM_PKT_FIFO_DROP_EN defined, the block SHALL implement a state machine with states ACCEPT and DROP, behaving as follows:
- ACCEPT: s_ready_o equals !full, or is 1 when full with a partial packet pending (wr_ptr != commit_ptr).
- ACCEPT to DROP: a word is accepted while full and a partial packet is pending. On that edge wr_ptr is rewound to commit_ptr, the word is discarded, and drop_count_o increments. If that word has last set, the state stays in ACCEPT.
- DROP: s_ready_o is 1 and all words are discarded. The state returns to ACCEPT on the edge accepting a last word.
- Buffer full of committed packets only: s_ready_o is 0.
REQ-029 Without STREAM_PKT_FIFO_DROP_EN, there SHALL be no DROP state, s_ready_o SHALL equal !full, and drop_count_o SHALL be tied to 0. Packets longer than DEPTH words are illegal in this build and stall the input permanently.

Structure
REQ-030 The package stream_pkg SHALL hold the state enum (ST_ACCEPT, ST_DROP) and the drop counter width constant (16).
REQ-031 The storage SHALL be one sub-module, stream_sdp_ram: simple dual-port, synchronous write, asynchronous read.

Verification
REQ-032 The bench SHALL cover these directed scenarios (DEPTH=16, T_DATA_WIDTH=8):
- 3-word packet with id=1 (0xA1, 0xA2, 0xA3 last) and m_ready_i=1: m_valid_o stays low until the cycle after 0xA3, then three words appear in order with m_id_o=1, and m_last_o is set on 0xA3 only.
- Four 4-word packets sent with m_ready_i=0: pkt_count_o=4, s_ready_o=0. Then one output transfer lets s_ready_o rise the next cycle.
- Commit and last-word read on the same edge: pkt_count_o is unchanged.
- DROP_EN defined, 20-word packet into an empty buffer, then a 2-word packet: drop_count_o=1, only the 2-word packet is output, and pkt_count_o=1.
- DROP_EN undefined, 20-word packet: s_ready_o stays 0 after 16 words, and m_valid_o stays 0.
- rst_n pulsed low mid-packet with 2 packets buffered: m_valid_o=0 and pkt_count_o=0 immediately; a new packet after release is output correctly.
